serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller. Sequences one shared fa_df full adder over WIDTH-bit

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/fa_df.sv | 23 ++
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// ============================================================================
// serial_add_pkg : shared state encoding and limits for serial_add_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_df.sv
// ============================================================================
// fa_df : dataflow 1-bit full adder
// Rev 1.0
// ============================================================================
`default_nettype none

module fa_df (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial WIDTH-bit adder, one fa_df step per clock, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_done;

    logic               w_s_bit;
    logic               w_c_bit;
    logic [WIDTH-1:0]   w_acc_next;

    fa_df u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_s_bit),
        .cout (w_c_bit)
    );

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_next = w_s_bit;
        end else begin : g_acc_wn
            assign w_acc_next = {w_s_bit, r_acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c_bit;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_c_bit;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == S_RUN);
    assign ready = ~busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// tb_serial_add_ctrl : directed and random checks of serial_add_ctrl (WIDTH=8)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one single-cycle start, scramble operands, wait for done (bounded).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          output int lat, output int bsy, output logic tmo);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        lat = 0; bsy = 0; tmo = 1'b0;
        while (!done) begin
            if (busy) bsy++;
            if (lat >= 40) begin
                tmo = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({cout, sum} !== 9'h000) begin failures++; $display("FAIL reset_result: got %h want 000", {cout, sum}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_carry_wrap();
        int lat, bsy;
        logic tmo;
        logic [7:0] s_hold;
        run_op(8'hFF, 8'h01, 1'b0, lat, bsy, tmo);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL wrap_timeout: done never seen"); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL wrap_latency: got %0d want 8", lat); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL wrap_sum: got %h want 00", sum); end
        checks++; if (cout !== 1'b1) begin failures++; $display("FAIL wrap_cout: got %b want 1", cout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_busy_at_done: got %b want 0", busy); end
        s_hold = sum;
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL wrap_done_pulse: got %b want 0", done); end
        checks++; if ({cout, s_hold} !== 9'h100 || {cout, sum} !== 9'h100) begin
            failures++; $display("FAIL wrap_hold: got %h want 100", {cout, sum});
        end
        tick();
    endtask

    task automatic test_cin_busy();
        int lat, bsy;
        logic tmo;
        run_op(8'h3C, 8'h0F, 1'b1, lat, bsy, tmo);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL cin_timeout: done never seen"); end
        checks++; if (sum !== 8'h4C) begin failures++; $display("FAIL cin_sum: got %h want 4c", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL cin_cout: got %b want 0", cout); end
        checks++; if (bsy !== 8) begin failures++; $display("FAIL cin_busy_cycles: got %0d want 8", bsy); end
        tick();
    endtask

    task automatic test_ignore_start();
        int n;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ign_ready: got %b want 0", ready); end
        a = 8'h11; b = 8'h22; start = 1'b1;
        tick();
        start = 1'b0;
        n = 4;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 8) begin failures++; $display("FAIL ign_latency: got %0d want 8", n); end
        checks++; if ({cout, sum} !== 9'h003) begin failures++; $display("FAIL ign_result: got %h want 003", {cout, sum}); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_restart: got busy %b want 0", busy); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, t1, t2;
        logic [8:0] r1, r2;
        t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'h80; b = 8'h80;
        n = 0;
        while (t2 < 0 && n < 60) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = n;
                    r1 = {cout, sum};
                    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_done: got %b want 1", ready); end
                end else begin
                    t2 = n;
                    r2 = {cout, sum};
                    start = 1'b0;
                end
            end
            tick();
            n++;
        end
        start = 1'b0;
        checks++; if (t1 !== 8) begin failures++; $display("FAIL b2b_first_done: got %0d want 8", t1); end
        checks++; if (t2 - t1 !== 9) begin failures++; $display("FAIL b2b_spacing: got %0d want 9", t2 - t1); end
        checks++; if (r1 !== 9'h002) begin failures++; $display("FAIL b2b_result1: got %h want 002", r1); end
        checks++; if (r2 !== 9'h100) begin failures++; $display("FAIL b2b_result2: got %h want 100", r2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_after: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if ({cout, sum} !== 9'h000) begin failures++; $display("FAIL rmid_result: got %h want 000", {cout, sum}); end
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_no_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_random();
        int lat, bsy;
        logic tmo;
        logic [7:0] ra, rb;
        logic rc;
        logic [8:0] exp;
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            run_op(ra, rb, rc, lat, bsy, tmo);
            checks++; if (tmo !== 1'b0 || {cout, sum} !== exp) begin
                failures++;
                $display("FAIL rand_%0d: %h+%h+%b got %h want %h (timeout=%b)", i, ra, rb, rc, {cout, sum}, exp, tmo);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_cin_busy();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
